mc_fetch_mem_unit: RTL and testbench

- Upstream neighbour of the multicycle control FSM in MCCPU.
- Owns the PC, IR, MDR and ALUOut architectural registers, the IorD address mux and the PCSource next-PC mux.
- Presents Op/Funct from IR to the controller and runs a ready/valid handshake to a variable-latency unified memory.
- Raises a stall that freezes the controller FSM until the access completes, with a watchdog that flags hung accesses.

---
 rtl/mc_fetch_mem_unit_pkg.sv | 14 +
 rtl/mc_fetch_mem_unit_if.sv | 11 +
 rtl/mc_fetch_mem_unit_mem_handshake.sv | 63 ++++++
 rtl/mc_fetch_mem_unit.sv | 61 ++++++
 tb/tb_mc_fetch_mem_unit.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mc_fetch_mem_unit_pkg.sv
// mc_fetch_mem_unit_pkg: shared encodings, field positions and next-PC selection for the fetch/memory unit
package mc_fetch_mem_unit_pkg;
  typedef enum logic [1:0] {PCSRC_ALU = 2'd0, PCSRC_ALUOUT = 2'd1, PCSRC_JUMP = 2'd2} pcsrc_e;
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  function automatic logic [31:0] sel_next_pc(logic [1:0] src, logic [31:0] alu_result, logic [31:0] alu_out,
                                              logic [3:0] pc_hi, logic [25:0] target);
    return src == PCSRC_ALUOUT ? alu_out : src == PCSRC_JUMP ? {pc_hi, target, 2'b00} : alu_result;
  endfunction
endpackage

// File: rtl/mc_fetch_mem_unit_if.sv
// mc_fetch_mem_unit_if: request/ready bus between the fetch unit and the unified memory
interface mc_fetch_mem_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mc_fetch_mem_unit_mem_handshake.sv
// mc_fetch_mem_unit_mem_handshake: IDLE/WAIT request FSM with request latches and a sticky watchdog
module mc_fetch_mem_unit_mem_handshake
  import mc_fetch_mem_unit_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        access,
  input  logic        we,
  input  logic        fetch,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  mc_fetch_mem_unit_if.master bus,
  output logic        stall,
  output logic        done,
  output logic        cur_fetch,
  output logic        bus_err
);
  state_e state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic we_q, fetch_q, err_q, idle;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == S_IDLE ? ((access && !bus.mem_ready) ? S_WAIT : S_IDLE)
                                : (bus.mem_ready ? S_IDLE : S_WAIT);
  // Request is gated by rstn so it drops the instant reset asserts, even mid-WAIT
  always_comb begin
    idle          = state_q == S_IDLE;
    bus.mem_req   = rstn & (idle ? access : 1'b1);
    bus.mem_we    = rstn & (idle ? access & we : we_q);
    bus.mem_addr  = idle ? addr : addr_q;
    bus.mem_wdata = idle ? wdata : wdata_q;
    cur_fetch     = idle ? fetch : fetch_q;
    done          = bus.mem_req & bus.mem_ready;
    stall         = bus.mem_req & ~bus.mem_ready;
  end
  always_comb
    cnt_d = !stall ? '0 : cnt_q == WAIT_W'(MAX_WAIT) ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      fetch_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (idle && stall) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        we_q    <= we;
        fetch_q <= fetch;
      end
      cnt_q <= cnt_d;
      err_q <= err_q | (cnt_d == WAIT_W'(MAX_WAIT));
    end
  assign bus_err = err_q;
endmodule

// File: rtl/mc_fetch_mem_unit.sv
// mc_fetch_mem_unit: PC/IR/MDR/ALUOut registers and address muxing in front of a stalling memory handshake
module mc_fetch_mem_unit
  import mc_fetch_mem_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          MAX_WAIT = 16,
  parameter int          WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        PCWrite,
  input  logic        IRWrite,
  input  logic        IorD,
  input  logic        MemWrite,
  input  logic [1:0]  PCSource,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  mc_fetch_mem_unit_if.master bus,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic [31:0] alu_out,
  output logic [5:0]  Op,
  output logic [5:0]  Funct,
  output logic        stall,
  output logic        bus_err
);
  logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d, alu_out_q, alu_out_d;
  logic done, cur_fetch;
  mc_fetch_mem_unit_mem_handshake #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_hs (
    .clk(clk), .rstn(rstn),
    .access(IRWrite | IorD), .we(IorD & MemWrite), .fetch(IRWrite & ~IorD),
    .addr(IorD ? alu_out_q : pc_q), .wdata(store_data),
    .bus(bus), .stall(stall), .done(done), .cur_fetch(cur_fetch), .bus_err(bus_err)
  );
  // The fetch completion edge is also the PC-increment edge since stall drops in that cycle
  always_comb begin
    pc_d      = (!stall && PCWrite) ? sel_next_pc(PCSource, alu_result, alu_out_q, pc_q[31:28], ir_q[25:0]) : pc_q;
    ir_d      = (done && cur_fetch) ? bus.mem_rdata : ir_q;
    mdr_d     = (done && !cur_fetch && !bus.mem_we) ? bus.mem_rdata : mdr_q;
    alu_out_d = stall ? alu_out_q : alu_result;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mdr_q     <= '0;
      alu_out_q <= '0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      alu_out_q <= alu_out_d;
    end
  assign pc      = pc_q;
  assign ir      = ir_q;
  assign mdr     = mdr_q;
  assign alu_out = alu_out_q;
  assign Op      = ir_q[OP_MSB:OP_LSB];
  assign Funct   = ir_q[FUNCT_MSB:FUNCT_LSB];
endmodule

// File: tb/tb_mc_fetch_mem_unit.sv
// tb_mc_fetch_mem_unit: directed vectors with a bus-transaction scoreboard and register checks
module tb_mc_fetch_mem_unit;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } txn_t;
  logic clk = 1'b0, rstn = 1'b0;
  logic PCWrite = 0, IRWrite = 0, IorD = 0, MemWrite = 0;
  logic [1:0] PCSource = 2'd0;
  logic [31:0] alu_result = 0, store_data = 0;
  logic [31:0] pc, ir, mdr, alu_out;
  logic [5:0] Op, Funct;
  logic stall, bus_err;
  int n_cmp = 0, n_bad = 0;
  txn_t sb[$];
  mc_fetch_mem_unit_if bus();
  mc_fetch_mem_unit dut (
    .clk(clk), .rstn(rstn), .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemWrite(MemWrite),
    .PCSource(PCSource), .alu_result(alu_result), .store_data(store_data), .bus(bus),
    .pc(pc), .ir(ir), .mdr(mdr), .alu_out(alu_out), .Op(Op), .Funct(Funct), .stall(stall), .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic idle_inputs();
    PCWrite = 0; IRWrite = 0; IorD = 0; MemWrite = 0; PCSource = 2'd0;
    bus.mem_ready = 0; store_data = 0;
  endtask
  always @(negedge clk)
    if (rstn && bus.mem_req && bus.mem_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_txn", 32'd1, 32'd0);
      else begin
        txn_t e;
        e = sb.pop_front();
        chk("sb_addr", bus.mem_addr, e.addr);
        chk("sb_we", {31'd0, bus.mem_we}, {31'd0, e.we});
        chk("sb_wdata", bus.mem_wdata, e.wdata);
      end
    end
  initial begin
    bus.mem_ready = 0;
    bus.mem_rdata = 0;
    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_mdr", mdr, 32'h0);
    chk("rst_alu_out", alu_out, 32'h0);
    chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    // zero-wait fetch
    rstn = 1;
    IRWrite = 1; PCWrite = 1; PCSource = 2'd0; alu_result = 32'd4;
    bus.mem_ready = 1; bus.mem_rdata = 32'h2008_0005;
    sb.push_back('{addr: 32'h0, we: 1'b0, wdata: 32'h0});
    #1;
    chk("zw_req", {31'd0, bus.mem_req}, 32'd1);
    chk("zw_stall", {31'd0, stall}, 32'd0);
    step();
    chk("zw_ir", ir, 32'h2008_0005);
    chk("zw_op", {26'd0, Op}, 32'h08);
    chk("zw_pc", pc, 32'd4);
    idle_inputs();
    step();
    // 3-wait fetch at pc=4, alu_result toggles while stalled
    IRWrite = 1; PCWrite = 1; alu_result = 32'd8; bus.mem_rdata = 32'h0109_5020;
    sb.push_back('{addr: 32'h4, we: 1'b0, wdata: 32'h0});
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("w3_stall", {31'd0, stall}, 32'd1);
      chk("w3_addr", bus.mem_addr, 32'h4);
      chk("w3_pc_hold", pc, 32'd4);
      chk("w3_ir_hold", ir, 32'h2008_0005);
      alu_result = 32'h100 << i;
      step();
    end
    alu_result = 32'd8; bus.mem_ready = 1;
    #1;
    chk("w3_done_stall", {31'd0, stall}, 32'd0);
    step();
    chk("w3_ir", ir, 32'h0109_5020);
    chk("w3_funct", {26'd0, Funct}, 32'h20);
    chk("w3_pc", pc, 32'd8);
    idle_inputs();
    alu_result = 32'h10;
    step();
    chk("ld_alu_out", alu_out, 32'h10);
    // load with 2 wait cycles
    IorD = 1; bus.mem_rdata = 32'hDEAD_BEEF; alu_result = 32'h999;
    sb.push_back('{addr: 32'h10, we: 1'b0, wdata: 32'h0});
    #1;
    chk("ld_addr", bus.mem_addr, 32'h10);
    step(); step();
    chk("ld_alu_out_hold", alu_out, 32'h10);
    bus.mem_ready = 1;
    step();
    chk("ld_mdr", mdr, 32'hDEAD_BEEF);
    chk("ld_ir_hold", ir, 32'h0109_5020);
    idle_inputs();
    alu_result = 32'h20;
    step();
    // store with store_data changed during WAIT
    IorD = 1; MemWrite = 1; store_data = 32'h1234;
    sb.push_back('{addr: 32'h20, we: 1'b1, wdata: 32'h1234});
    #1;
    chk("st_we", {31'd0, bus.mem_we}, 32'd1);
    chk("st_wdata", bus.mem_wdata, 32'h1234);
    step();
    store_data = 32'h5555;
    #1;
    chk("st_wdata_hold", bus.mem_wdata, 32'h1234);
    chk("st_we_hold", {31'd0, bus.mem_we}, 32'd1);
    step();
    bus.mem_ready = 1;
    step();
    chk("st_mdr_hold", mdr, 32'hDEAD_BEEF);
    idle_inputs();
    // mem_ready with no request is ignored
    bus.mem_ready = 1; bus.mem_rdata = 32'hFFFF_0000;
    step();
    chk("ign_ir", ir, 32'h0109_5020);
    chk("ign_mdr", mdr, 32'hDEAD_BEEF);
    idle_inputs();
    // fetch a jump at pc=8 while moving pc to 0x0040_0008
    IRWrite = 1; PCWrite = 1; alu_result = 32'h0040_0008;
    bus.mem_ready = 1; bus.mem_rdata = 32'h0810_0000;
    sb.push_back('{addr: 32'h8, we: 1'b0, wdata: 32'h0});
    step();
    chk("j_pc_pre", pc, 32'h0040_0008);
    chk("j_op", {26'd0, Op}, 32'h02);
    idle_inputs();
    PCWrite = 1; PCSource = 2'd2;
    step();
    chk("j_pc", pc, 32'h0040_0000);
    PCSource = 2'd1; alu_result = 32'h77;
    step();
    chk("src1_pc", pc, 32'h0040_0008);
    chk("src1_alu_out", alu_out, 32'h77);
    PCSource = 2'd3; alu_result = 32'h88;
    step();
    chk("src3_pc", pc, 32'h88);
    idle_inputs();
    // watchdog: never answer the fetch
    IRWrite = 1;
    for (int i = 1; i <= 18; i++) begin
      step();
      chk("wd_bus_err", {31'd0, bus_err}, (i >= 16) ? 32'd1 : 32'd0);
    end
    chk("wd_stall", {31'd0, stall}, 32'd1);
    rstn = 0;
    #1;
    chk("ar_req", {31'd0, bus.mem_req}, 32'd0);
    chk("ar_bus_err", {31'd0, bus_err}, 32'd0);
    chk("ar_pc", pc, 32'h0);
    chk("ar_stall", {31'd0, stall}, 32'd0);
    idle_inputs();
    step();
    rstn = 1;
    step();
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
